// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA channel priority arbiter.
// Optional demand-mode continuation is enabled by DMA_ARB_DEMAND_EN.
package dma_arb_pkg;

   localparam int         NUM_CH        = 4;
   localparam logic [7:0] DEFAULT_ORDER = 8'b11_10_01_00;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      GRANT,
      RELEASE
   } arb_state_t;

   // Serviced channel c drops to the lowest slot; c+1 becomes field0.
   function automatic logic [7:0] rotate_order(input logic [1:0] c);
      logic [1:0] c1;
      logic [1:0] c2;
      logic [1:0] c3;
      c1 = c + 2'd1;
      c2 = c + 2'd2;
      c3 = c + 2'd3;
      return {c, c3, c2, c1};
   endfunction

endpackage

// File: rtl/dma_prio_encoder.sv
// Picks the first requesting channel in a 4-field priority order.
// Combinational; field0 of the order is the highest priority.
module dma_prio_encoder
   import dma_arb_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  logic [7:0]        order,
   output logic [1:0]        winner,
   output logic              found
);

   always_comb begin
      winner = 2'd0;
      found  = 1'b0;
      // Walk lowest priority first so field0 has the final say.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req[order[2*i +: 2]]) begin
            winner = order[2*i +: 2];
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter with HRQ/HLDA hold sequencing and DACK drive.
// Define DMA_ARB_DEMAND_EN for demand-mode grant continuation.
module dma_priority_arbiter
   import dma_arb_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic [NUM_CH-1:0] DREQ,
   input  logic              dreqSenseLow,
   input  logic [NUM_CH-1:0] maskReg,
   input  logic              priorityType,
   input  logic              HLDA,
   input  logic              serviceDone,
   input  logic              eop,
   output logic              HRQ,
   output logic [NUM_CH-1:0] DACK,
   output logic [1:0]        activeCh,
   output logic              grantValid,
   output logic [7:0]        priorityOrder
);

   arb_state_t        state;
   arb_state_t        state_n;
   logic              hrq_n;
   logic [NUM_CH-1:0] dack_n;
   logic [1:0]        ch_n;
   logic              gv_n;
   logic [7:0]        order_n;
   logic [NUM_CH-1:0] req;
   logic [1:0]        winner;
   logic              found;
   logic              keep;

   assign req = (DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg;

   dma_prio_encoder u_enc (
      .req    (req),
      .order  (priorityOrder),
      .winner (winner),
      .found  (found)
   );

`ifdef DMA_ARB_DEMAND_EN
   assign keep = req[activeCh];
`else
   assign keep = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state         <= IDLE;
         HRQ           <= 1'b0;
         DACK          <= '0;
         activeCh      <= 2'd0;
         grantValid    <= 1'b0;
         priorityOrder <= DEFAULT_ORDER;
      end else begin
         state         <= state_n;
         HRQ           <= hrq_n;
         DACK          <= dack_n;
         activeCh      <= ch_n;
         grantValid    <= gv_n;
         priorityOrder <= order_n;
      end
   end

   always_comb begin
      state_n = state;
      hrq_n   = HRQ;
      dack_n  = DACK;
      ch_n    = activeCh;
      gv_n    = grantValid;
      order_n = priorityType ? priorityOrder : DEFAULT_ORDER;
      unique case (state)
         IDLE: begin
            if (|req) begin
               state_n = REQ;
               hrq_n   = 1'b1;
            end
         end
         REQ: begin
            if (!found) begin
               state_n = IDLE;
               hrq_n   = 1'b0;
            end else if (HLDA) begin
               state_n = GRANT;
               ch_n    = winner;
               dack_n  = 4'b0001 << winner;
               gv_n    = 1'b1;
            end
         end
         GRANT: begin
            // CPU revoke wins over any end-of-service indication.
            if (!HLDA) begin
               state_n = IDLE;
               hrq_n   = 1'b0;
               dack_n  = '0;
               gv_n    = 1'b0;
            end else if (eop || (serviceDone && !keep)) begin
               state_n = RELEASE;
               hrq_n   = 1'b0;
               dack_n  = '0;
               gv_n    = 1'b0;
               if (priorityType) begin
                  order_n = rotate_order(activeCh);
               end
            end
         end
         RELEASE: begin
            hrq_n  = 1'b0;
            dack_n = '0;
            gv_n   = 1'b0;
            if (!HLDA) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter with a behavioural reference model.
// Build with DMA_ARB_DEMAND_EN defined to exercise demand-mode continuation.
module tb_dma_priority_arbiter;

`ifdef DMA_ARB_DEMAND_EN
   localparam bit DEMAND = 1'b1;
`else
   localparam bit DEMAND = 1'b0;
`endif

   logic       CLK;
   logic       RESET;
   logic [3:0] DREQ;
   logic       dreqSenseLow;
   logic [3:0] maskReg;
   logic       priorityType;
   logic       HLDA;
   logic       serviceDone;
   logic       eop;
   logic       HRQ;
   logic [3:0] DACK;
   logic [1:0] activeCh;
   logic       grantValid;
   logic [7:0] priorityOrder;

   int checks = 0;
   int errors = 0;

   dma_priority_arbiter dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .DREQ          (DREQ),
      .dreqSenseLow  (dreqSenseLow),
      .maskReg       (maskReg),
      .priorityType  (priorityType),
      .HLDA          (HLDA),
      .serviceDone   (serviceDone),
      .eop           (eop),
      .HRQ           (HRQ),
      .DACK          (DACK),
      .activeCh      (activeCh),
      .grantValid    (grantValid),
      .priorityOrder (priorityOrder)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mph 0=idle 1=requesting 2=granted 3=releasing.
   int mo[4];
   int mph;
   bit mhrq;
   bit mgv;
   int mch;
   bit mvalid = 1'b0;

   function automatic int packed_order();
      return (mo[3] << 6) | (mo[2] << 4) | (mo[1] << 2) | mo[0];
   endfunction

   always @(posedge CLK) begin
      logic [3:0] r;
      int w;
      bit f;
      bit leave;
      r = (DREQ ^ {4{dreqSenseLow}}) & ~maskReg;
      f = 1'b0;
      w = 0;
      for (int i = 0; i < 4; i++) begin
         if (!f && r[mo[i]]) begin
            f = 1'b1;
            w = mo[i];
         end
      end
      if (RESET) begin
         mph = 0; mhrq = 0; mgv = 0; mch = 0;
         for (int i = 0; i < 4; i++) mo[i] = i;
         mvalid = 1'b1;
      end else if (mvalid) begin
         if (!priorityType) for (int i = 0; i < 4; i++) mo[i] = i;
         case (mph)
            0: if (f) begin mph = 1; mhrq = 1; end
            1: begin
               if (!f) begin mph = 0; mhrq = 0; end
               else if (HLDA) begin mph = 2; mch = w; mgv = 1; end
            end
            2: begin
               leave = eop || (serviceDone && !(DEMAND && r[mch]));
               if (!HLDA) begin mph = 0; mhrq = 0; mgv = 0; end
               else if (leave) begin
                  mph = 3; mhrq = 0; mgv = 0;
                  if (priorityType)
                     for (int i = 0; i < 4; i++) mo[i] = (mch + 1 + i) % 4;
               end
            end
            default: if (!HLDA) mph = 0;
         endcase
      end
   end

   always @(negedge CLK) begin
      if (mvalid) begin
         check("cmp_hrq", HRQ, mhrq);
         check("cmp_dack", DACK, mgv ? (1 << mch) : 0);
         check("cmp_gv", grantValid, mgv);
         check("cmp_order", priorityOrder, packed_order());
         check("cmp_onehot", $onehot0(DACK), 1);
         if (mgv) check("cmp_ch", activeCh, mch);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wait_hrq();
      int k;
      k = 0;
      while (!HRQ && k < 20) begin
         step(1);
         k++;
      end
      check("hrq_timeout", HRQ, 1);
   endtask

   // Full handshake; returns after release with HLDA low again.
   task automatic grant_cycle(input logic [3:0] exp_dack, input bit end_eop);
      wait_hrq();
      HLDA = 1'b1;
      step(1);
      check("lit_grant_dack", DACK, exp_dack);
      serviceDone = 1'b1;
      eop = end_eop;
      step(1);
      serviceDone = 1'b0;
      eop = 1'b0;
      check("lit_rel_dack", DACK, 0);
      check("lit_rel_hrq", HRQ, 0);
      HLDA = 1'b0;
      step(1);
   endtask

   initial begin
      RESET = 1'b1; DREQ = 4'b0; dreqSenseLow = 1'b0; maskReg = 4'b0;
      priorityType = 1'b0; HLDA = 1'b0; serviceDone = 1'b0; eop = 1'b0;
      step(2);
      check("lit_rst_hrq", HRQ, 0);
      check("lit_rst_dack", DACK, 0);
      check("lit_rst_order", priorityOrder, 8'b11_10_01_00);
      RESET = 1'b0;
      step(1);

      // Fixed priority, channel 1 of 1010 wins.
      DREQ = 4'b1010;
      step(1);
      check("lit_fix_hrq", HRQ, 1);
      step(1);
      HLDA = 1'b1;
      step(1);
      check("lit_fix_dack", DACK, 4'b0010);
      check("lit_fix_ch", activeCh, 1);
      serviceDone = 1'b1;
      DREQ = 4'b0;
      step(1);
      serviceDone = 1'b0;
      check("lit_fix_done_dack", DACK, 0);
      check("lit_fix_done_hrq", HRQ, 0);
      check("lit_fix_order", priorityOrder, 8'b11_10_01_00);
      HLDA = 1'b0;
      step(2);

      // Rotating priority across all four channels.
      priorityType = 1'b1;
      DREQ = 4'b1111;
      grant_cycle(4'b0001, DEMAND);
      check("lit_rot_order", priorityOrder, 8'b00_11_10_01);
      grant_cycle(4'b0010, DEMAND);
      grant_cycle(4'b0100, DEMAND);
      grant_cycle(4'b1000, DEMAND);
      DREQ = 4'b0;
      priorityType = 1'b0;
      step(2);

      // Masked requests never raise HRQ.
      maskReg = 4'b0001;
      DREQ = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("lit_mask1_hrq", HRQ, 0);
      end
      maskReg = 4'b1111;
      DREQ = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("lit_maskall_hrq", HRQ, 0);
      end
      maskReg = 4'b0;
      DREQ = 4'b0;
      step(2);

      // Higher-priority request arriving before HLDA wins.
      DREQ = 4'b0100;
      wait_hrq();
      DREQ = 4'b0101;
      step(1);
      HLDA = 1'b1;
      step(1);
      check("lit_preempt_dack", DACK, 4'b0001);
      serviceDone = 1'b1;
      DREQ = 4'b0;
      step(1);
      serviceDone = 1'b0;
      HLDA = 1'b0;
      step(2);

      // Active-low sense: raw 1011 means only channel 2 requests.
      dreqSenseLow = 1'b1;
      DREQ = 4'b1011;
      wait_hrq();
      HLDA = 1'b1;
      step(1);
      check("lit_sense_dack", DACK, 4'b0100);
      eop = 1'b1;
      DREQ = 4'b1111;
      step(1);
      eop = 1'b0;
      HLDA = 1'b0;
      dreqSenseLow = 1'b0;
      DREQ = 4'b0;
      step(2);

      // CPU revoke together with serviceDone: abort, no rotation.
      priorityType = 1'b1;
      DREQ = 4'b0010;
      wait_hrq();
      HLDA = 1'b1;
      step(1);
      check("lit_rev_grant", DACK, 4'b0010);
      HLDA = 1'b0;
      serviceDone = 1'b1;
      step(1);
      serviceDone = 1'b0;
      check("lit_rev_dack", DACK, 0);
      check("lit_rev_hrq", HRQ, 0);
      check("lit_rev_order", priorityOrder, 8'b11_10_01_00);

      // Reset in the middle of a grant.
      wait_hrq();
      HLDA = 1'b1;
      step(1);
      check("lit_pre_rst_gv", grantValid, 1);
      RESET = 1'b1;
      step(1);
      check("lit_midrst_hrq", HRQ, 0);
      check("lit_midrst_dack", DACK, 0);
      check("lit_midrst_gv", grantValid, 0);
      check("lit_midrst_ch", activeCh, 0);
      check("lit_midrst_order", priorityOrder, 8'b11_10_01_00);
      RESET = 1'b0;
      HLDA = 1'b0;
      DREQ = 4'b0;
      priorityType = 1'b0;
      step(2);

`ifdef DMA_ARB_DEMAND_EN
      // Demand mode: grant survives serviceDone until eop.
      DREQ = 4'b0001;
      wait_hrq();
      HLDA = 1'b1;
      step(1);
      check("lit_dem_start", DACK, 4'b0001);
      for (int i = 0; i < 3; i++) begin
         serviceDone = 1'b1;
         step(1);
         serviceDone = 1'b0;
         check("lit_dem_hold", DACK, 4'b0001);
         step(1);
         check("lit_dem_hold2", DACK, 4'b0001);
      end
      eop = 1'b1;
      step(1);
      eop = 1'b0;
      check("lit_dem_eop", DACK, 0);
      HLDA = 1'b0;
      DREQ = 4'b0;
      step(2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
